// File: rtl/link_pkg.sv
// Shared definitions for the req/ack byte link.
// Used by both the master and slave sides.
package link_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_HIGH = 2'd1,
        REQ_LOW  = 2'd2,
        ERR      = 2'd3
    } link_state_e;

endpackage

// File: rtl/link_master_fsm_if.sv
// Host write port plus req/ack link signals of the link master.
// master: the link master itself; slave: the host/link partner side.
interface link_master_fsm_if
    import link_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              req;
    logic [DATA_W-1:0] data_out;
    logic              ack;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic              fatal_err;
    logic [7:0]        sent_count;

    modport master (
        input  wr_en, wr_data, ack,
        output full, req, data_out, busy,
        output done, timeout_err, fatal_err, sent_count
    );

    modport slave (
        output wr_en, wr_data, ack,
        input  full, req, data_out, busy,
        input  done, timeout_err, fatal_err, sent_count
    );

endinterface

// File: rtl/link_byte_fifo.sv
// Synchronous byte queue with a registered full flag.
// Writes are refused whenever full_o is set, even if a pop happens alongside.
module link_byte_fifo
    import link_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic [AW:0]       cnt_d;
    logic              full_q;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Power-of-2 depth lets the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = full_q;

endmodule

// File: rtl/link_master_fsm.sv
// Link master: queues host bytes and sends each over a four-phase req/ack handshake,
// with per-edge ack timeouts, a sticky fatal error and an acked-byte counter.
module link_master_fsm
    import link_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input logic              clk,
    input logic              rst,
    link_master_fsm_if.master lnk
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    link_state_e       state_q;
    logic [TW-1:0]     timer_q;
    logic              req_q;
    logic [DATA_W-1:0] data_q;
    logic              done_q;
    logic              tout_q;
    logic              fatal_q;
    logic [7:0]        cnt_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_data;
    logic              pop;

    assign pop = (state_q == IDLE) && !fifo_empty;

    link_byte_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (lnk.wr_en),
        .data_i  (lnk.wr_data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            fatal_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            tout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        data_q  <= fifo_data;
                        req_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= REQ_HIGH;
                    end
                end
                REQ_HIGH: begin
                    if (lnk.ack) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= cnt_q + 8'd1;
                        timer_q <= '0;
                        state_q <= REQ_LOW;
                    end else if (timer_q == TMAX) begin
                        req_q   <= 1'b0;
                        tout_q  <= 1'b1;
                        timer_q <= '0;
                        state_q <= REQ_LOW;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                REQ_LOW: begin
                    if (!lnk.ack) begin
                        state_q <= IDLE;
                    end else if (timer_q == TMAX) begin
                        fatal_q <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ERR: begin
                    req_q   <= 1'b0;
                    fatal_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lnk.full        = fifo_full;
    assign lnk.req         = req_q;
    assign lnk.data_out    = data_q;
    assign lnk.busy        = (state_q != IDLE) || !fifo_empty;
    assign lnk.done        = done_q;
    assign lnk.timeout_err = tout_q;
    assign lnk.fatal_err   = fatal_q;
    assign lnk.sent_count  = cnt_q;

endmodule

// File: tb/tb_link_master_fsm.sv
// Self-checking bench for link_master_fsm with a behavioural slave and byte scoreboard.
module tb_link_master_fsm;
    import link_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    link_master_fsm_if #(.DATA_W(DW)) bus ();

    link_master_fsm #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lnk (bus)
    );

    int errors = 0;
    int checks = 0;

    // slave behaviour: 0 acks after ack_dly cycles, 1 never acks, 2 ack stuck high
    int   slave_mode = 0;
    int   ack_dly    = 3;
    bit   rand_ack   = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_sent = 8'd0;

    int   n_done = 0;
    int   n_tout = 0;
    int   n_rise = 0;
    int   hi_run = 0;
    int   last_hi = 0;
    int   lo_run = 0;
    int   min_lo = 1000;
    logic prev_req = 1'b0;

    initial begin
        int cnt;
        cnt = 0;
        bus.ack = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (rst) begin
                bus.ack = 1'b0;
                cnt = 0;
            end else begin
                case (slave_mode)
                    0: begin
                        if (bus.req && !bus.ack) begin
                            cnt++;
                            if (cnt >= ack_dly) begin
                                bus.ack = 1'b1;
                                rx_q.push_back(bus.data_out);
                                cnt = 0;
                                if (rand_ack) ack_dly = $urandom_range(1, 6);
                            end
                        end else if (!bus.req && bus.ack) begin
                            bus.ack = 1'b0;
                        end
                    end
                    1: bus.ack = 1'b0;
                    default: begin
                        if (bus.req && !bus.ack) begin
                            bus.ack = 1'b1;
                            rx_q.push_back(bus.data_out);
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                hi_run = 0;
                lo_run = 0;
            end else begin
                if (bus.done) n_done++;
                if (bus.timeout_err) n_tout++;
                if (bus.req) begin
                    if (!prev_req) begin
                        n_rise++;
                        if (lo_run < min_lo) min_lo = lo_run;
                    end
                    hi_run++;
                    lo_run = 0;
                end else begin
                    if (prev_req) last_hi = hi_run;
                    hi_run = 0;
                    lo_run++;
                end
                prev_req = bus.req;
            end
        end
    end

    function automatic bit same_q(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic write_one(input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (bus.req) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            sample();
            if (!bus.busy && !bus.ack) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_sent = 8'd0;
    endtask

    task automatic test_reset();
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        do_reset();
        sample();
        checks++;
        if ({bus.req, bus.done, bus.timeout_err, bus.fatal_err, bus.busy, bus.full} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.req, bus.done, bus.timeout_err, bus.fatal_err, bus.busy, bus.full});
        end
        checks++;
        if (bus.sent_count !== 8'd0 || bus.data_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: count=%0d data=%h want 0/00",
                     bus.sent_count, bus.data_out);
        end
    endtask

    task automatic test_single();
        int d0;
        bit ok;
        slave_mode = 0;
        rand_ack = 1'b0;
        ack_dly = 3;
        rx_q.delete();
        d0 = n_done;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        sample();
        checks++;
        if (bus.req !== 1'b0) begin
            errors++;
            $display("FAIL single_req_early: req=%b want 0", bus.req);
        end
        sample();
        checks++;
        if (bus.req !== 1'b1 || bus.data_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_req_rise: req=%b data=%h want 1/a5", bus.req, bus.data_out);
        end
        wait_idle(ok);
        exp_sent = exp_sent + 8'd1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_idle: busy=%b stuck, want 0", bus.busy);
        end
        checks++;
        if (n_done - d0 !== 1 || bus.sent_count !== exp_sent) begin
            errors++;
            $display("FAIL single_done: pulses=%0d count=%0d want 1/%0d",
                     n_done - d0, bus.sent_count, exp_sent);
        end
        exp_q = '{8'hA5};
        checks++;
        if (!same_q(rx_q, exp_q)) begin
            errors++;
            $display("FAIL single_data: got %0d bytes first=%h want a5",
                     rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'h00);
        end
    endtask

    task automatic test_burst();
        int d0;
        bit ok;
        slave_mode = 0;
        rand_ack = 1'b0;
        ack_dly = 8;
        rx_q.delete();
        d0 = n_done;
        min_lo = 1000;
        write_one(8'h01);
        wait_req(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL burst_first_req: req=0 want 1");
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(2 + k);
            sample();
            if (k == 3) begin
                checks++;
                if (bus.full !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_three: full=%b want 0", bus.full);
                end
            end
            if (k == 4) begin
                checks++;
                if (bus.full !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_full: full=%b want 1", bus.full);
                end
            end
        end
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        wait_idle(ok);
        exp_sent = exp_sent + 8'd5;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        checks++;
        if (!ok || !same_q(rx_q, exp_q)) begin
            errors++;
            $display("FAIL burst_order: got %0d bytes last=%h want 5 ending 05",
                     rx_q.size(), rx_q.size() > 0 ? rx_q[rx_q.size()-1] : 8'h00);
        end
        checks++;
        if (bus.sent_count !== exp_sent || n_done - d0 !== 5) begin
            errors++;
            $display("FAIL burst_count: count=%0d pulses=%0d want %0d/5",
                     bus.sent_count, n_done - d0, exp_sent);
        end
        checks++;
        if (min_lo < 1) begin
            errors++;
            $display("FAIL burst_gap: min req-low cycles=%0d want >=1", min_lo);
        end
    endtask

    task automatic test_timeout();
        int t0;
        int d0;
        bit seen;
        bit ok;
        slave_mode = 1;
        rx_q.delete();
        t0 = n_tout;
        d0 = n_done;
        seen = 1'b0;
        write_one(8'h3C);
        for (int i = 0; i < 60 && !seen; i++) begin
            sample();
            if (n_tout != t0) seen = 1'b1;
        end
        checks++;
        if (!seen || last_hi !== TO || bus.req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_len: seen=%b req_high=%0d req=%b want 1/%0d/0",
                     seen, last_hi, bus.req, TO);
        end
        wait_idle(ok);
        checks++;
        if (!ok || n_tout - t0 !== 1 || n_done != d0 || bus.sent_count !== exp_sent) begin
            errors++;
            $display("FAIL timeout_after: idle=%b tout=%0d done=%0d count=%0d want 1/1/0/%0d",
                     ok, n_tout - t0, n_done - d0, bus.sent_count, exp_sent);
        end
        slave_mode = 0;
    endtask

    task automatic test_random();
        int r0;
        int d0;
        int accepted;
        int nbytes;
        bit ok;
        logic [7:0] b;
        slave_mode = 0;
        rand_ack = 1'b1;
        ack_dly = $urandom_range(1, 6);
        rx_q.delete();
        exp_q.delete();
        r0 = n_rise;
        d0 = n_done;
        accepted = 0;
        nbytes = 24;
        for (int n = 0; n < nbytes; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            for (int w = 0; w < 200; w++) begin
                if (accepted - (n_rise - r0) < DEPTH - 1) break;
                @(posedge clk);
            end
            b = 8'($urandom);
            write_one(b);
            exp_q.push_back(b);
            accepted++;
        end
        wait_idle(ok);
        rand_ack = 1'b0;
        exp_sent = exp_sent + 8'(nbytes);
        checks++;
        if (!ok || !same_q(rx_q, exp_q)) begin
            errors++;
            $display("FAIL random_stream: idle=%b got %0d bytes want %0d in order",
                     ok, rx_q.size(), exp_q.size());
        end
        checks++;
        if (bus.sent_count !== exp_sent || n_done - d0 !== nbytes) begin
            errors++;
            $display("FAIL random_count: count=%0d pulses=%0d want %0d/%0d",
                     bus.sent_count, n_done - d0, exp_sent, nbytes);
        end
    endtask

    task automatic test_full_pop();
        bit ok;
        bit hit;
        logic pr;
        slave_mode = 0;
        rand_ack = 1'b0;
        ack_dly = 8;
        rx_q.delete();
        write_one(8'h11);
        wait_req(ok);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'h21 + k);
        end
        @(posedge clk);
        #1;
        bus.wr_data = 8'h99;
        sample();
        checks++;
        if (bus.full !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_full: full=%b want 1", bus.full);
        end
        pr = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (bus.req && !pr) begin
                bus.wr_en = 1'b0;
                hit = 1'b1;
            end
            pr = bus.req;
        end
        bus.wr_en = 1'b0;
        sample();
        checks++;
        if (!hit || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_drop: pop_seen=%b full=%b want 1/0", hit, bus.full);
        end
        wait_idle(ok);
        exp_sent = exp_sent + 8'd5;
        exp_q = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};
        checks++;
        if (!ok || !same_q(rx_q, exp_q) || bus.sent_count !== exp_sent) begin
            errors++;
            $display("FAIL fullpop_stream: got %0d bytes count=%0d want 5/%0d",
                     rx_q.size(), bus.sent_count, exp_sent);
        end
    endtask

    task automatic test_fatal();
        int d0;
        int r0;
        int dly;
        bit seen;
        slave_mode = 2;
        rx_q.delete();
        d0 = n_done;
        seen = 1'b0;
        dly = 0;
        write_one(8'h5A);
        for (int i = 0; i < 40 && !seen; i++) begin
            sample();
            if (n_done != d0) seen = 1'b1;
        end
        for (int i = 1; i <= 40 && seen && dly == 0; i++) begin
            sample();
            if (bus.fatal_err) dly = i;
        end
        exp_sent = exp_sent + 8'd1;
        checks++;
        if (dly !== TO) begin
            errors++;
            $display("FAIL fatal_delay: cycles=%0d want %0d", dly, TO);
        end
        checks++;
        if (bus.sent_count !== exp_sent || rx_q.size() != 1) begin
            errors++;
            $display("FAIL fatal_count: count=%0d rx=%0d want %0d/1",
                     bus.sent_count, rx_q.size(), exp_sent);
        end
        r0 = n_rise;
        for (int k = 0; k < DEPTH + 1; k++) write_one(8'(8'hC0 + k));
        repeat (8) sample();
        checks++;
        if (bus.full !== 1'b1 || bus.req !== 1'b0 || n_rise != r0) begin
            errors++;
            $display("FAIL fatal_hold: full=%b req=%b rises=%0d want 1/0/0",
                     bus.full, bus.req, n_rise - r0);
        end
        checks++;
        if (bus.fatal_err !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL fatal_sticky: fatal=%b busy=%b want 1/1", bus.fatal_err, bus.busy);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int r0;
        slave_mode = 0;
        rand_ack = 1'b0;
        do_reset();
        checks++;
        if (bus.fatal_err !== 1'b0) begin
            errors++;
            $display("FAIL areset_fatal: fatal=%b want 0", bus.fatal_err);
        end
        ack_dly = 3;
        write_one(8'hB1);
        wait_idle(ok);
        ack_dly = 12;
        write_one(8'hB2);
        wait_req(ok);
        write_one(8'hB3);
        write_one(8'hB4);
        sample();
        checks++;
        if (bus.req !== 1'b1 || bus.sent_count !== 8'd1) begin
            errors++;
            $display("FAIL areset_pre: req=%b count=%0d want 1/1", bus.req, bus.sent_count);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req !== 1'b0 || bus.sent_count !== 8'd0) begin
            errors++;
            $display("FAIL areset_async: req=%b count=%0d want 0/0", bus.req, bus.sent_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        r0 = n_rise;
        sample();
        checks++;
        if (bus.full !== 1'b0 || bus.busy !== 1'b0 || bus.req !== 1'b0) begin
            errors++;
            $display("FAIL areset_release: full=%b busy=%b req=%b want 0/0/0",
                     bus.full, bus.busy, bus.req);
        end
        repeat (6) sample();
        checks++;
        if (n_rise != r0) begin
            errors++;
            $display("FAIL areset_flush: rises=%0d want 0", n_rise - r0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_timeout();
        test_random();
        test_full_pop();
        test_fatal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
